// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
// Sits between the ps2_keyboard receiver FIFO and downstream consumers.
// It pops bytes from the receiver and recovers from receiver overflow. It
// parses the make / F0 break / E0 extended scan-code grammar, tracks the
// shift and caps-lock state, and queues decoded key events in a small
// first-word-fall-through FIFO.
//
// Optional build macro: TYPEMATIC_FILTER_EN. When it is defined, a make
// that repeats the last made {ext, code} is discarded. That make is not
// pushed and does not count in key_count.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   kb_data           receiver head byte
//   kb_ready          receiver FIFO non-empty
//   kb_overflow       receiver FIFO overflowed
//   kb_nextdata_n     active-low pop strobe to the receiver (one cycle per byte)
//   kb_clrn           active-low clear to the receiver
//   evt_valid         event FIFO non-empty
//   evt_ready         consumer accepts the head event
//   evt_code          scan code of the head event
//   evt_ascii         ASCII of the head event, 0x00 if non-printable
//   evt_break         head event is a release
//   evt_ext           head event had an E0 prefix
//   shift_held        left (0x12) or right (0x59) shift is down
//   caps_lock         caps-lock toggle state
//   key_count         make events queued, wraps
//   drop_count        overflow recoveries, saturates at 0xFF
//   fsm_state         debug view of the byte-pop FSM
//
// Event handshake: the head event is held stable while evt_valid is high.
// It is removed on a clk edge where evt_valid && evt_ready. evt_ready has
// no effect while evt_valid is low. evt_* fields read 0 while evt_valid is low.
module ps2_key_sequencer #(
  parameter int EVT_DEPTH = 4,
  parameter int PTR_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             kb_clrn,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic [7:0]       evt_ascii,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             shift_held,
  output logic             caps_lock,
  output logic [7:0]       key_count,
  output logic [7:0]       drop_count,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam int         EVT_W  = 18;

  logic [1:0]       state;
  logic [7:0]       byte_q;
  logic             ext_q;
  logic             brk_q;
  logic             shift_l;
  logic             shift_r;
  logic [EVT_W-1:0] mem [EVT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             do_push;
  logic             do_pop;
  logic             is_prefix;
  logic             is_discard;
  logic             filt_hit;
  logic [7:0]       ascii_c;

  // Lower-case / digit / control mapping for non-extended codes.
  function automatic logic [7:0] map_ascii(input logic [7:0] c);
    case (c)
      8'h1C: map_ascii = 8'h61; 8'h32: map_ascii = 8'h62; 8'h21: map_ascii = 8'h63;
      8'h23: map_ascii = 8'h64; 8'h24: map_ascii = 8'h65; 8'h2B: map_ascii = 8'h66;
      8'h34: map_ascii = 8'h67; 8'h33: map_ascii = 8'h68; 8'h43: map_ascii = 8'h69;
      8'h3B: map_ascii = 8'h6A; 8'h42: map_ascii = 8'h6B; 8'h4B: map_ascii = 8'h6C;
      8'h3A: map_ascii = 8'h6D; 8'h31: map_ascii = 8'h6E; 8'h44: map_ascii = 8'h6F;
      8'h4D: map_ascii = 8'h70; 8'h15: map_ascii = 8'h71; 8'h2D: map_ascii = 8'h72;
      8'h1B: map_ascii = 8'h73; 8'h2C: map_ascii = 8'h74; 8'h3C: map_ascii = 8'h75;
      8'h2A: map_ascii = 8'h76; 8'h1D: map_ascii = 8'h77; 8'h22: map_ascii = 8'h78;
      8'h35: map_ascii = 8'h79; 8'h1A: map_ascii = 8'h7A;
      8'h45: map_ascii = 8'h30; 8'h16: map_ascii = 8'h31; 8'h1E: map_ascii = 8'h32;
      8'h26: map_ascii = 8'h33; 8'h25: map_ascii = 8'h34; 8'h2E: map_ascii = 8'h35;
      8'h36: map_ascii = 8'h36; 8'h3D: map_ascii = 8'h37; 8'h3E: map_ascii = 8'h38;
      8'h46: map_ascii = 8'h39;
      8'h29: map_ascii = 8'h20;
      8'h66: map_ascii = 8'h08;
      default: map_ascii = 8'h00;
    endcase
  endfunction

  assign shift_held = shift_l | shift_r;
  assign fsm_state  = state;
  assign fifo_full  = (count == EVT_DEPTH[PTR_W:0]);
  assign evt_valid  = (count != '0);
  assign do_pop     = evt_valid && evt_ready;

  // ASCII is taken from the modifier state before this byte is decoded.
  // An overflow in the POP cycle wins, and the latched byte is lost.
  always_comb begin
    is_prefix  = (byte_q == 8'hE0) || (byte_q == 8'hF0);
    is_discard = (byte_q inside {8'h00, 8'hFF, 8'hAA, 8'hEE, 8'hFA});
    ascii_c    = 8'h00;
    if (!brk_q) begin
      if (byte_q == 8'h5A) begin
        ascii_c = 8'h0D;
      end else if (!ext_q) begin
        ascii_c = map_ascii(byte_q);
        if ((ascii_c inside {[8'h61:8'h7A]}) && (shift_held ^ caps_lock))
          ascii_c = ascii_c - 8'h20;
      end
    end
    do_push = (state == S_POP) && !kb_overflow && !is_prefix && !is_discard && !filt_hit;
  end

`ifdef TYPEMATIC_FILTER_EN
  // {ext, code} of the last make. The value 0 cannot match, because a
  // byte of 0x00 is always discarded.
  logic [8:0] last_q;
  assign filt_hit = !brk_q && ({ext_q, byte_q} == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if ((state == S_POP) && !kb_overflow && !is_prefix && !is_discard) begin
      if (brk_q) begin
        if ({ext_q, byte_q} == last_q) last_q <= '0;
      end else begin
        last_q <= {ext_q, byte_q};
      end
    end
  end
`else
  assign filt_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      byte_q        <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      shift_l       <= 1'b0;
      shift_r       <= 1'b0;
      caps_lock     <= 1'b0;
      key_count     <= '0;
      drop_count    <= '0;
      kb_nextdata_n <= 1'b1;
      kb_clrn       <= 1'b0;
    end else begin
      // The clear follows overflow directly. It stays low for as long as
      // overflow is held.
      kb_clrn <= !kb_overflow;
      if (kb_overflow) begin
        state         <= S_IDLE;
        kb_nextdata_n <= 1'b1;
        ext_q         <= 1'b0;
        brk_q         <= 1'b0;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else begin
        case (state)
          S_IDLE: begin
            // Gating on not-full is what back-pressures the receiver.
            if (kb_ready && !fifo_full) begin
              byte_q        <= kb_data;
              kb_nextdata_n <= 1'b0;
              state         <= S_POP;
            end
          end
          S_POP: begin
            kb_nextdata_n <= 1'b1;
            state         <= S_WAIT;
            if (byte_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
              if (do_push) begin
                if (!brk_q) key_count <= key_count + 8'd1;
                if (!ext_q) begin
                  if (byte_q == 8'h12) shift_l <= !brk_q;
                  if (byte_q == 8'h59) shift_r <= !brk_q;
                  if ((byte_q == 8'h58) && !brk_q) caps_lock <= !caps_lock;
                end
              end
            end
          end
          S_WAIT:  state <= S_IDLE;  // lets the receiver's ready settle
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {byte_q, ascii_c, brk_q, ext_q};
  end

  assign {evt_code, evt_ascii, evt_break, evt_ext} = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Controller between the ps2_keyboard receiver FIFO and downstream consumers (text console, game logic).
- Sequences the receiver's ready/nextdata_n pop handshake and manages overflow recovery by driving the receiver's clrn.
- Parses the make / F0 break / E0 extended scan-code grammar and tracks shift and caps-lock state.
- Queues decoded key events, with ASCII, in a small FWFT event FIFO with a valid/ready interface.

Parameters:
- EVT_DEPTH, 4, event FIFO entries; power of 2, >= 2.
- PTR_W, 2, log2(EVT_DEPTH).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- kb_data  in  8  receiver head byte.
- kb_ready  in  1  receiver FIFO non-empty.
- kb_overflow  in  1  receiver FIFO overflowed.
- kb_nextdata_n  out  1  active-low pop strobe to receiver.
- kb_clrn  out  1  active-low clear to receiver.
- evt_valid  out  1  event FIFO non-empty.
- evt_ready  in  1  consumer accepts head event.
- evt_code  out  8  scan code of head event.
- evt_ascii  out  8  ASCII of head event; 0x00 if non-printable.
- evt_break  out  1  head event is a release.
- evt_ext  out  1  head event had E0 prefix.
- shift_held  out  1  left (0x12) or right (0x59) shift is down.
- caps_lock  out  1  caps-lock toggle state.
- key_count  out  8  count of make events queued; wraps.
- drop_count  out  8  count of overflow recoveries; saturates at 0xFF.

Behaviour:
- Reset values: kb_nextdata_n=1, kb_clrn=0, evt_valid=0, evt_* head fields=0, shift_held=0, caps_lock=0, key_count=0, drop_count=0, FSM=S_IDLE, ext/brk flags=0, FIFO empty.
- kb_clrn goes 1 on the first clk edge after rst deasserts, unless kb_overflow is high.
- FSM states: S_IDLE, S_POP, S_WAIT.
- S_IDLE: if kb_ready && FIFO not full && !kb_overflow, latch kb_data into byte_q, drive kb_nextdata_n<=0, and go to S_POP. Otherwise stay.
- S_POP: kb_nextdata_n<=1; decode byte_q (below); go to S_WAIT.
- S_WAIT: go to S_IDLE. This cycle gives the receiver's ready time to settle.
- kb_nextdata_n is low for exactly one cycle per byte. Maximum throughput is one byte per 3 clk.
- Decode rules (in S_POP):
  - 0xE0: set ext.
  - 0xF0: set brk.
  - 0x00, 0xFF, 0xAA, 0xEE, 0xFA: discard and clear ext/brk.
  - Any other byte: push event {code, ascii, brk, ext}, then clear ext/brk.
- Latency: the event is visible on evt_* at edge N+1, where edge N is the byte-latch edge.
- Modifiers, non-ext only:
  - 0x12/0x59 make sets, and break clears, an internal per-side bit; shift_held = L | R.
  - 0x58 make toggles caps_lock; 0x58 break has no effect.
  - Modifier events are still queued.
- ASCII mapping (computed at push time using modifier state before this byte):
  - Letter codes map to 0x61-0x7A; uppercase 0x41-0x5A when shift_held ^ caps_lock.
  - Digit row maps to 0x30-0x39; shift does not affect digits.
  - 0x29 maps to 0x20.
  - 0x5A maps to 0x0D, with or without ext.
  - 0x66 maps to 0x08.
  - Everything else, all other ext codes, and all break events map to 0x00.
- key_count increments on every pushed make event (brk=0), 0xFF→0x00.
- Event FIFO behaviour:
  - First-word-fall-through; pop when evt_valid && evt_ready.
  - Push and pop in the same cycle: both occur, occupancy unchanged.
  - A push never targets a full FIFO, because S_IDLE gates on not-full. Full therefore back-pressures the receiver.
  - evt_ready while empty: no effect.
- Overflow:
  - kb_overflow=1 in any state: kb_clrn<=0 for one cycle, flush ext/brk, FSM→S_IDLE, drop_count+1 (saturating).
  - The event FIFO, shift state and caps state are kept.
  - If kb_overflow stays high, kb_clrn stays low.
- rst mid-sequence: immediate return to reset values. A partially received E0/F0 prefix is lost.

Optional Feature:
- TYPEMATIC_FILTER_EN defined:
  - A register holds the last made {ext, code}.
  - A make whose {ext, code} equals it is discarded, with no push and no key_count increment.
  - A matching break clears the register; any other make overwrites it.
- Not defined: every typematic repeat make is queued.

Test Plan:
- Bytes 0x1C, F0, 0x1C, evt_ready=1 → two events: {1C, 0x61, brk0, ext0} then {1C, 0x00, brk1, ext0}. key_count=1. kb_nextdata_n pulses low 3×, one cycle each.
- Bytes 12, 1C, F0 12, 1C → shift_held=1 during the first 1C (ascii 0x41), then 0 for the second 1C (0x61). Two key_count increments for the 1C makes plus one for 12.
- 58 make, 1C, 12, 1C → caps_lock=1; first 1C → 0x41; with shift also held, the second 1C → 0x61.
- E0 5A, E0 F0 5A → {5A, 0x0D, ext1, brk0} then {5A, 0x00, ext1, brk1}. Stray FA bytes are dropped.
- evt_ready=0, 6 makes offered → 4 events queued and kb_ready left high. Raising evt_ready drains the FIFO and the remaining 2 bytes are consumed in order.
- kb_overflow pulse after a lone E0 → kb_clrn low 1 cycle, drop_count=1, next byte 0x1C gives an event with ext0. With TYPEMATIC_FILTER_EN, 1C 1C 1C → one event.
